// File: rtl/mbc_arbiter.sv
// mbc_arbiter: two-port round-robin arbiter sharing the memory bus controller's processor interface
// Optional feature macro: MBC_ARB_TIMEOUT_EN (BUSY watchdog, gives up after TIMEOUT cycles)
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   reqN, addrN, wdataN, bN, hN, rwN  requester N (0 = instruction fetch, 1 = load/store), req held until doneN
//   gntN                              one-cycle pulse: request of port N latched
//   doneN                             one-cycle pulse: transaction of port N finished
//   err, rdata                        status and read data, valid with done (rdata held until next done)
//   busy                              a transaction is outstanding
//   mbc_address .. mbc_enable         request fields and enable towards the controller
//   mbc_mem_rdy, mbc_error_drs        controller ready / error state
//   mbc_d_read                        controller read data
module mbc_arbiter #(
    parameter int AW = 25,
    parameter int DW = 32
`ifdef MBC_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic          b0,
    input  logic          h0,
    input  logic          b1,
    input  logic          h1,
    input  logic          rw0,
    input  logic          rw1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [AW-1:0] mbc_address,
    output logic [DW-1:0] mbc_d_write,
    output logic          mbc_b,
    output logic          mbc_h,
    output logic          mbc_r_w,
    output logic          mbc_enable,
    input  logic          mbc_mem_rdy,
    input  logic          mbc_error_drs,
    input  logic [DW-1:0] mbc_d_read
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_BUSY    = 3'd2;
    localparam logic [2:0] S_ERR_CLR = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0] r_state;
    logic       r_last;
    logic       r_owner;
    logic       r_err;
    logic       r_seen_low;
    logic       w_any;
    logic       w_win;
    logic       w_timeout;

    // a contested grant goes to the port that was not served last
    assign w_any = req0 | req1;
    assign w_win = (req0 & req1) ? ~r_last : req1;

    always_comb begin
        // grants are combinational, so they are gated while reset is held
        gnt0       = reset_n & (r_state == S_IDLE) & w_any & ~w_win;
        gnt1       = reset_n & (r_state == S_IDLE) & w_any & w_win;
        done0      = (r_state == S_DONE) & ~r_owner;
        done1      = (r_state == S_DONE) & r_owner;
        err        = (r_state == S_DONE) & r_err;
        busy       = r_state != S_IDLE;
        // hold off the issue while the controller is still booting
        mbc_enable = ((r_state == S_ISSUE) & mbc_mem_rdy) | (r_state == S_ERR_CLR);
    end

`ifdef MBC_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] r_cnt;
    // the count reaches TIMEOUT-1 during the TIMEOUT-th BUSY cycle
    assign w_timeout = r_cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cnt <= '0;
        else if (r_state == S_ISSUE)
            r_cnt <= '0;
        else if (r_state == S_BUSY)
            r_cnt <= r_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_err       <= 1'b0;
            r_seen_low  <= 1'b0;
            rdata       <= '0;
            mbc_address <= '0;
            mbc_d_write <= '0;
            mbc_b       <= 1'b0;
            mbc_h       <= 1'b0;
            mbc_r_w     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_state     <= S_ISSUE;
                    r_owner     <= w_win;
                    r_last      <= w_win;
                    r_err       <= 1'b0;
                    mbc_address <= w_win ? addr1 : addr0;
                    mbc_d_write <= w_win ? wdata1 : wdata0;
                    mbc_b       <= w_win ? b1 : b0;
                    mbc_h       <= w_win ? h1 : h0;
                    mbc_r_w     <= w_win ? rw1 : rw0;
                end
                S_ISSUE: if (mbc_mem_rdy) begin
                    r_state    <= S_BUSY;
                    r_seen_low <= 1'b0;
                end
                S_BUSY: begin
                    // ready is only trusted once the controller has dropped it for this access
                    if (!mbc_mem_rdy)
                        r_seen_low <= 1'b1;
                    if (mbc_error_drs)
                        r_state <= S_ERR_CLR;
                    else if (mbc_mem_rdy && r_seen_low) begin
                        r_state <= S_DONE;
                        if (!mbc_r_w)
                            rdata <= mbc_d_read;
                    end else if (w_timeout) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                    end
                end
                S_ERR_CLR: begin
                    r_state <= S_DONE;
                    r_err   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mbc_arbiter.sv
// tb_mbc_arbiter: self-checking bench for mbc_arbiter with a cycle-stepped controller and requester model
module tb_mbc_arbiter;
    localparam int AW = 25;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b1, req1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          b0 = 1'b0, h0 = 1'b0, b1 = 1'b0, h1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
    logic          gnt0, gnt1, done0, done1, err, busy;
    logic [DW-1:0] rdata;
    logic [AW-1:0] mbc_address;
    logic [DW-1:0] mbc_d_write;
    logic          mbc_b, mbc_h, mbc_r_w, mbc_enable;
    logic          mbc_mem_rdy = 1'b1, mbc_error_drs = 1'b0;
    logic [DW-1:0] mbc_d_read = '0;

    mbc_arbiter #(
        .AW(AW),
        .DW(DW)
`ifdef MBC_ARB_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .b0(b0), .h0(h0), .b1(b1), .h1(h1),
        .rw0(rw0), .rw1(rw1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rdata(rdata), .busy(busy),
        .mbc_address(mbc_address), .mbc_d_write(mbc_d_write), .mbc_b(mbc_b), .mbc_h(mbc_h),
        .mbc_r_w(mbc_r_w), .mbc_enable(mbc_enable), .mbc_mem_rdy(mbc_mem_rdy),
        .mbc_error_drs(mbc_error_drs), .mbc_d_read(mbc_d_read)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // requester-side model: what each port has asked for and who was served last
    logic [1:0]    pend;
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd [2];
    logic          p_rw [2], p_b [2], p_h [2];
    int            m_last;
    logic [DW-1:0] m_rdata;

    typedef struct {
        logic [1:0]    rq;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rw, b, h;
        int            lat, early;
        logic          inj;
        logic [DW-1:0] data;
        int            exp_port;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] fields();
        return 64'({mbc_address, mbc_d_write, mbc_b, mbc_h, mbc_r_w});
    endfunction

    function automatic int pick();
        return (pend == 2'b11) ? 1 - m_last : (pend[1] ? 1 : 0);
    endfunction

    task automatic set_req(input int p, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic rw, input logic b, input logic h);
        pend[p] = 1'b1; p_addr[p] = a; p_wd[p] = wd; p_rw[p] = rw; p_b[p] = b; p_h[p] = h;
        if (p == 0) begin req0 = 1; addr0 = a; wdata0 = wd; rw0 = rw; b0 = b; h0 = h; end
        else        begin req1 = 1; addr1 = a; wdata1 = wd; rw1 = rw; b1 = b; h1 = h; end
    endtask

    // requester gives up its request and changes its fields after being granted
    task automatic scramble(input int p);
        if (p == 0) begin req0 = 0; addr0 = AW'($urandom); wdata0 = $urandom; rw0 = ~rw0; b0 = ~b0; end
        else        begin req1 = 0; addr1 = AW'($urandom); wdata1 = $urandom; rw1 = ~rw1; b1 = ~b1; end
    endtask

    task automatic release_req(input int p);
        if (p == 0) req0 = 0; else req1 = 0;
    endtask

    // reset ends just after a rising edge, so requests set next are granted on the following cycle
    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset_n = 0;
        #1;
        chk("rst_ctl", 64'({gnt1, gnt0, done1, done0, err, busy, mbc_enable}), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        chk("rst_fields", fields(), 64'(0));
        req0 = 0; req1 = 0; mbc_error_drs = 0; mbc_mem_rdy = rdy;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1;
        pend = 2'b00; m_last = 1; m_rdata = '0;
    endtask

    // One full transaction. Called while the DUT is in DONE or right after a rising edge in IDLE.
    task automatic do_txn(input int lat, input logic inj, input logic [DW-1:0] data, input logic drop,
                          input int boot, input int early, input int exp_port);
        logic [63:0] e_f;
        logic        e_rw;
        @(negedge clk); #1;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("gnt", 64'({gnt1, gnt0}), 64'(exp_port == 1 ? 2'b10 : 2'b01));
        e_f = 64'({p_addr[exp_port], p_wd[exp_port], p_b[exp_port], p_h[exp_port], p_rw[exp_port]});
        e_rw = p_rw[exp_port];
        pend[exp_port] = 1'b0;
        m_last = exp_port;
        @(posedge clk); #1;
        if (drop) scramble(exp_port);
        for (int i = 0; i < boot; i++) begin
            @(negedge clk); mbc_mem_rdy = 0; #1;
            chk("boot_hold", 64'({mbc_enable, busy}), 64'(2'b01));
        end
        @(negedge clk); mbc_mem_rdy = 1; #1;
        chk("issue_en", 64'(mbc_enable), 64'(1));
        chk("issue_gnt", 64'({gnt1, gnt0}), 64'(0));
        chk("issue_fields", fields(), e_f);
        for (int i = 0; i < early; i++) begin
            @(negedge clk); mbc_mem_rdy = 1; #1;
            chk("early_rdy", 64'({mbc_enable, done1, done0}), 64'(0));
        end
        for (int i = 0; i < lat; i++) begin
            @(negedge clk); mbc_mem_rdy = 0; mbc_d_read = $urandom; #1;
            chk("busy_wait", 64'({mbc_enable, done1, done0}), 64'(0));
        end
        @(negedge clk);
        if (inj) begin mbc_error_drs = 1; mbc_mem_rdy = 0; end
        else     begin mbc_mem_rdy = 1; mbc_d_read = data; end
        #1;
        if (inj) begin
            @(negedge clk); #1;
            chk("errclr_en", 64'({mbc_enable, done1, done0}), 64'(3'b100));
        end
        @(negedge clk);
        mbc_error_drs = 0; mbc_mem_rdy = 1; mbc_d_read = $urandom;
        release_req(exp_port);
        #1;
        if (!inj && !e_rw) m_rdata = data;
        chk("done", 64'({done1, done0}), 64'(exp_port == 1 ? 2'b10 : 2'b01));
        chk("done_err", 64'(err), 64'(inj));
        chk("done_rdata", 64'(rdata), 64'(m_rdata));
        chk("done_state", 64'({gnt1, gnt0, mbc_enable, busy}), 64'(1));
        chk("done_fields", fields(), e_f);
    endtask

    initial begin
        tbl[0] = '{2'b01, 25'h000010, 32'h0, 1'b0, 1'b0, 1'b0, 4, 0, 1'b0, 32'hDEADBEEF, 0};
        tbl[1] = '{2'b11, 25'h000040, 32'h0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 32'h11111111, 1};
        tbl[2] = '{2'b10, 25'h000080, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b0, 3, 0, 1'b0, 32'h22222222, 0};
        tbl[3] = '{2'b01, 25'h0000C0, 32'h0, 1'b0, 1'b1, 1'b0, 1, 2, 1'b0, 32'h33333333, 1};
        tbl[4] = '{2'b10, 25'h000003, 32'h5A5A0000, 1'b1, 1'b0, 1'b1, 2, 0, 1'b0, 32'h44444444, 0};
        tbl[5] = '{2'b00, 25'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3, 0, 1'b1, 32'h55555555, 1};
        tbl[6] = '{2'b10, 25'h1FFFFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 32'h66666666, 1};
        tbl[7] = '{2'b11, 25'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 5, 0, 1'b0, 32'h77777777, 0};
        tbl[8] = '{2'b00, 25'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2, 1, 1'b0, 32'h88888888, 1};

        do_reset(1'b1);
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].rq[0]) set_req(0, tbl[i].addr, tbl[i].wd, tbl[i].rw, tbl[i].b, tbl[i].h);
            if (tbl[i].rq[1]) set_req(1, tbl[i].addr, tbl[i].wd, tbl[i].rw, tbl[i].b, tbl[i].h);
            do_txn(tbl[i].lat, tbl[i].inj, tbl[i].data, 1'b0, 0, tbl[i].early, tbl[i].exp_port);
        end

        // controller still booting after reset: grant at once, enable held off for 20 cycles
        do_reset(1'b0);
        set_req(0, 25'h000020, 32'h0, 1'b0, 1'b0, 1'b0);
        do_txn(2, 1'b0, 32'hCAFEF00D, 1'b0, 20, 0, 0);

        // reset while BUSY: aborted access produces no done
        set_req(0, 25'h000055, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1 chk("ab_gnt", 64'({gnt1, gnt0}), 64'(2'b01));
        @(negedge clk); #1 chk("ab_en", 64'(mbc_enable), 64'(1));
        @(negedge clk); mbc_mem_rdy = 0; #1 chk("ab_busy", 64'({busy, mbc_enable}), 64'(2'b10));
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1 chk("ab_quiet", 64'({done1, done0, busy, gnt1, gnt0}), 64'(0));
        end
        @(posedge clk); #1;
        set_req(1, 25'h000100, 32'h12345678, 1'b1, 1'b0, 1'b0);
        do_txn(1, 1'b0, 32'h0, 1'b0, 0, 0, 1);

        for (int n = 0; n < 60; n++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    set_req(p, AW'($urandom), $urandom, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (pend == 2'b00)
                set_req(int'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'b0, 1'b0, 1'b0);
            do_txn(int'($urandom_range(1, 6)), $urandom_range(0, 5) == 0, $urandom,
                   $urandom_range(0, 3) == 0, 0, ($urandom_range(0, 3) == 0) ? 1 : 0, pick());
        end

`ifdef MBC_ARB_TIMEOUT_EN
        do_reset(1'b1);
        set_req(0, 25'h000044, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk); #1 chk("to_gnt", 64'({gnt1, gnt0}), 64'(2'b01));
        @(negedge clk); #1 chk("to_en", 64'(mbc_enable), 64'(1));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); mbc_mem_rdy = 0; #1;
            chk("to_wait", 64'({done1, done0, mbc_enable}), 64'(0));
        end
        @(negedge clk); #1;
        chk("to_done", 64'({done1, done0, err}), 64'(3'b011));
        chk("to_rdata", 64'(rdata), 64'(0));
        req0 = 0; mbc_mem_rdy = 1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
